// File: rtl/nixie_tube_pkg.sv
// Shared constants for the nixie_tube_scan display driver: digit field layout,
// the active-low seven-segment decode table and the "dark" output values.
package nixie_tube_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Index = hex value, bits = gfedcba, 0 = segment on.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    an_onehot_low = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/nixie_tube_scan_seg7_decode.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_decode
  import nixie_tube_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[val_i];

endmodule

// File: rtl/nixie_tube_scan.sv
// Four-digit multiplexed 7-segment driver with registered active-low outputs.
// Optional leading-zero blanking is enabled by defining NIXIE_TUBE_LEADING_ZERO_BLANK_EN.
module nixie_tube_scan
  import nixie_tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] DATA,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;

  logic [3:0] digit_val [NUM_DIGITS];
  logic       digit_dp  [NUM_DIGITS];

  logic [3:0] sel_val;
  logic       sel_dp;
  logic [6:0] dec_seg;
  logic       blank;

  logic [6:0] seg_d;
  logic [3:0] an_d;
  logic       dp_d;

  logic unused_data;
  assign unused_data = ^DATA[31:20];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_field
      assign digit_val[gi] = DATA[gi*DIGIT_W +: 4];
      assign digit_dp[gi]  = DATA[gi*DIGIT_W + 4];
    end
  endgenerate

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // The outputs track the digit that will be lit after this edge, so DATA
  // reaches the pins with a single cycle of latency.
  assign sel_val = digit_val[idx_d];
  assign sel_dp  = digit_dp[idx_d];

  seg7_decode u_decode (
    .val_i (sel_val),
    .seg_o (dec_seg)
  );

`ifdef NIXIE_TUBE_LEADING_ZERO_BLANK_EN
  // zero_from[k]: fields k..3 are all zero, value and dp alike.
  logic [NUM_DIGITS-1:0] zero_from;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign zero_from[gi] = (digit_val[gi] == 4'd0) && !digit_dp[gi];
      end else begin : g_low
        assign zero_from[gi] = zero_from[gi+1] && (digit_val[gi] == 4'd0) && !digit_dp[gi];
      end
    end
  endgenerate

  assign blank = (idx_d != 2'd0) && zero_from[idx_d];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = an_onehot_low(idx_d);
    seg_d = blank ? SEG_BLANK : dec_seg;
    dp_d  = blank ? 1'b1 : ~sel_dp;
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      seg       <= SEG_BLANK;
      an        <= AN_OFF;
      dp        <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg       <= seg_d;
      an        <= an_d;
      dp        <= dp_d;
    end
  end

endmodule

// File: tb/tb_nixie_tube_scan.sv
// Self-checking bench for nixie_tube_scan: table vectors, hand sequences and
// randomized traffic against an edge-count based reference model.
module tb_nixie_tube_scan;

  localparam int SD = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] DATA;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  always #5 HCLK = ~HCLK;

  nixie_tube_scan #(.SCAN_DIV(SD)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .DATA    (DATA),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  int tests = 0;
  int fails = 0;
  int n_edges = 0;

  logic [6:0] ref_lut [16];

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } row_t;

  row_t rows [4];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got an/seg/dp=%b_%b_%b required %b_%b_%b (edge %0d)",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], n_edges);
    end
  endtask

  // Digit shown after n non-reset edges is floor(n/SD) mod 4.
  function automatic logic [11:0] model_out(input bit r, input int n, input logic [31:0] d);
    int k;
    logic [4:0] f;
    logic [3:0] a;
    logic [6:0] s;
    logic p;
    if (r) return {4'hF, 7'h7F, 1'b1};
    k = (n / SD) % 4;
    f = 5'((d >> (5 * k)) & 32'h1F);
    a = 4'hF & ~(4'b0001 << k);
    s = ref_lut[f[3:0]];
    p = ~f[4];
`ifdef NIXIE_TUBE_LEADING_ZERO_BLANK_EN
    if (k > 0 && ((d & 32'h000F_FFFF) >> (5 * k)) == 0) begin
      s = 7'h7F;
      p = 1'b1;
    end
`endif
    return {a, s, p};
  endfunction

  task automatic step(input logic r, input logic [31:0] d);
    HRESETn = r;
    DATA    = d;
    @(posedge HCLK);
    #1;
    if (r) n_edges = 0;
    else   n_edges++;
    check("model", {an, seg, dp}, model_out(r, n_edges, d));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] plan_data;

    ref_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    plan_data = 32'b0000_0000_0000_00100_00011_10010_00001;
    rows[0] = '{an: 4'b1110, seg: 7'b1111001, dp: 1'b1};
    rows[1] = '{an: 4'b1101, seg: 7'b0100100, dp: 1'b0};
    rows[2] = '{an: 4'b1011, seg: 7'b0110000, dp: 1'b1};
    rows[3] = '{an: 4'b0111, seg: 7'b0011001, dp: 1'b1};

    HRESETn = 1'b1;
    DATA    = 32'h0;
    #2;

    // Reset holds the display dark.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, plan_data);
      check("reset_dark", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end

    // First dwell after release is digit 0, then the table repeats.
    for (int i = 1; i < SD; i++) begin
      step(1'b0, plan_data);
      check("table_d0_first", {an, seg, dp}, {rows[0].an, rows[0].seg, rows[0].dp});
    end
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 4; i++) begin
        for (int c = 0; c < SD; c++) begin
          step(1'b0, plan_data);
          check("table", {an, seg, dp}, {rows[i % 4].an, rows[i % 4].seg, rows[i % 4].dp});
        end
      end
    end

    // Hex sweep in field 0 with junk in bits 31:20.
    for (int v = 0; v < 16; v++) begin
      d = {12'hFFF, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 4'(v)};
      for (int c = 0; c < 4 * SD; c++) begin
        step(1'b0, d);
        if (an == 4'b1110) check("sweep", {an, seg, 1'b0}, {4'b1110, ref_lut[v], 1'b0});
      end
    end

    // Field 2 changes while digit 2 is lit.
    step(1'b1, plan_data);
    while (n_edges < 2 * SD + 1) step(1'b0, plan_data);
    d = plan_data;
    d[14:10] = 5'b10111;
    step(1'b0, d);
    check("midchange", {an, seg, dp}, {4'b1011, ref_lut[7], 1'b0});
    while (n_edges < 3 * SD - 1) begin
      step(1'b0, d);
      check("midchange_hold", {an, 8'h00}, {4'b1011, 8'h00});
    end
    step(1'b0, d);
    check("midchange_next", {an, 8'h00}, {4'b0111, 8'h00});

    // Reset while digit 2 is lit.
    step(1'b1, d);
    while (n_edges < 2 * SD + 1) step(1'b0, d);
    step(1'b1, d);
    check("midreset_dark", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    step(1'b0, d);
    check("midreset_d0", {an, seg, dp}, {4'b1110, ref_lut[1], 1'b1});

`ifdef NIXIE_TUBE_LEADING_ZERO_BLANK_EN
    step(1'b1, 32'h5);
    for (int c = 0; c < 4 * SD; c++) begin
      step(1'b0, 32'h5);
      if (an == 4'b1110) check("blank_d0", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});
      else               check("blank_hi", {4'h0, seg, dp}, {4'h0, 7'h7F, 1'b1});
    end
    for (int c = 0; c < 4 * SD; c++) begin
      step(1'b0, 32'h0000_4005);
      if (an == 4'b1101)      check("unblank_d1", {an, seg, dp}, {4'b1101, ref_lut[0], 1'b1});
      else if (an == 4'b1011) check("unblank_d2", {an, seg, dp}, {4'b1011, ref_lut[0], 1'b0});
      else if (an == 4'b0111) check("still_blank_d3", {an, seg, dp}, {4'b0111, 7'h7F, 1'b1});
    end
`endif

    // Randomized traffic with sparse fields and occasional reset.
    d = $urandom;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       d = $urandom;
          1:       d = $urandom & 32'h0000_001F;
          default: d = $urandom & 32'h0000_03FF;
        endcase
      end
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
